// File: rtl/riscv_keypad_scanner.sv
// riscv_keypad_scanner
// Scans a 4x4 active-low matrix keypad, synchronizes and debounces the rows,
// and holds the last accepted key code for the IO bridge keyboard read port.
//
// Parameters:
//   SCAN_DIV  clock cycles each column is driven (>= 4)
//   DEBOUNCE  consecutive identical full-scan results to accept press/release (>= 2)
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-low reset
//   row_in     keypad rows, active-low, asynchronous to clk
//   col_out    column drive, active-low, exactly one bit low
//   keyboard   last accepted key code {row[1:0], col[1:0]}
//   key_down   high while the accepted key is held
//   key_event  one-cycle pulse per accepted press
module riscv_keypad_scanner #(
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] keyboard,
  output logic       key_down,
  output logic       key_event
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_t;

  // Scan side
  logic [DIV_W-1:0] div_cnt;
  logic [1:0]       col;
  logic [3:0]       row_meta;
  logic [3:0]       row_s;
  logic             acc_found;
  logic [3:0]       acc_code;
  logic             scan_done;
  logic             scan_found;
  logic [3:0]       scan_code;

  logic             dwell_end;
  logic [1:0]       row_idx;
  logic             sample_found;
  logic [3:0]       sample_code;

  assign dwell_end = (div_cnt == DIV_LAST);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    row_idx = 2'd0;
    // Descending loop: the last hit written wins, i.e. the lowest pressed row.
    for (int r = 3; r >= 0; r--) begin
      if (!row_s[r]) row_idx = 2'(r);
    end
  end

  // Once a position is latched in this scan, later columns cannot override it.
  assign sample_found = acc_found | (row_s != 4'hF);
  assign sample_code  = acc_found ? acc_code : {row_idx, col};

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      div_cnt    <= '0;
      col        <= 2'd0;
      col_out    <= 4'b1110;
      // NOTE: the synchronizer flops reset to "no row pulled low" so the first
      // samples after reset cannot look like a press.
      row_meta   <= 4'hF;
      row_s      <= 4'hF;
      acc_found  <= 1'b0;
      acc_code   <= 4'h0;
      scan_done  <= 1'b0;
      scan_found <= 1'b0;
      scan_code  <= 4'h0;
    end else begin
      row_meta  <= row_in;
      row_s     <= row_meta;
      scan_done <= 1'b0;
      if (dwell_end) begin
        div_cnt <= '0;
        col     <= col + 2'd1;
        col_out <= {col_out[2:0], col_out[3]};
        if (col == 2'd3) begin
          // Column 3 sample completes the scan: publish and start afresh.
          scan_done  <= 1'b1;
          scan_found <= sample_found;
          scan_code  <= sample_code;
          acc_found  <= 1'b0;
          acc_code   <= 4'h0;
        end else begin
          acc_found <= sample_found;
          acc_code  <= sample_code;
        end
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  // Debounce side
  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
  logic [3:0]       cand, cand_n;
  logic [3:0]       keyboard_n;
  logic             key_down_n;
  logic             key_event_n;
  logic             match_held;

  assign cnt_inc    = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
  assign match_held = scan_found && (scan_code == keyboard);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cand      <= 4'h0;
      keyboard  <= 4'h0;
      key_down  <= 1'b0;
      key_event <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      cand      <= cand_n;
      keyboard  <= keyboard_n;
      key_down  <= key_down_n;
      key_event <= key_event_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    cand_n      = cand;
    keyboard_n  = keyboard;
    key_down_n  = key_down;
    key_event_n = 1'b0;
    if (scan_done) begin
      unique case (state)
        IDLE: begin
          if (scan_found) begin
            state_n = PRESS_WAIT;
            cand_n  = scan_code;
            cnt_n   = CNT_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!scan_found) begin
            state_n = IDLE;
          end else if (scan_code != cand) begin
            cand_n = scan_code;
            cnt_n  = CNT_ONE;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n     = HELD;
              keyboard_n  = cand;
              key_down_n  = 1'b1;
              key_event_n = 1'b1;
            end
          end
        end
        HELD: begin
          if (!match_held) begin
            state_n = RELEASE_WAIT;
            cnt_n   = CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (match_held) begin
            state_n = HELD;
          end else begin
            cnt_n = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_n    = IDLE;
              key_down_n = 1'b0;
            end
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_keypad_scanner.sv
// Testbench for riscv_keypad_scanner with SCAN_DIV=4, DEBOUNCE=3.
// A keypad model pulls row r low while col_out[c] is low and key (r,c) is
// pressed. Directed scenarios check timing windows; a randomized phase is
// checked scan by scan against a run-length reference model.
module tb_riscv_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEBOUNCE = 3;
  localparam int PERIOD   = 4 * SCAN_DIV;
  localparam int LAT_MIN  = (DEBOUNCE - 1) * PERIOD;
  localparam int LAT_MAX  = (DEBOUNCE + 1) * PERIOD + 3;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] keyboard;
  logic       key_down;
  logic       key_event;

  logic [15:0] keys = 16'h0;  // bit r*4+c = key (r,c) pressed

  int n_checks = 0;
  int n_pass   = 0;
  int ev_cnt   = 0;

  // Reference model state
  int m_kb;
  int m_held;
  int m_run;
  int m_last;

  always #5 clk = ~clk;

  riscv_keypad_scanner #(
    .SCAN_DIV(SCAN_DIV),
    .DEBOUNCE(DEBOUNCE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .row_in   (row_in),
    .col_out  (col_out),
    .keyboard (keyboard),
    .key_down (key_down),
    .key_event(key_event)
  );

  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (key_event === 1'b1) ev_cnt++;
  end

  // Scan result by priority: lowest column, then lowest row; -1 if none.
  function automatic int prio(input logic [15:0] k);
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (k[r*4+c]) return r * 4 + c;
      end
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_kb = 0; m_held = 0; m_run = 0; m_last = -1;
  endtask

  // Accept after DEBOUNCE identical consecutive results; release after
  // DEBOUNCE consecutive results that differ from the held code.
  task automatic model_scan(input int res, output bit ev);
    ev = 1'b0;
    if (m_held == 0) begin
      if (res < 0) m_run = 0;
      else if (res == m_last && m_run > 0) m_run++;
      else m_run = 1;
      m_last = res;
      if (m_run >= DEBOUNCE) begin
        m_held = 1; m_kb = res; ev = 1'b1; m_run = 0;
      end
    end else begin
      if (res == m_kb) m_run = 0;
      else m_run++;
      if (m_run >= DEBOUNCE) begin
        m_held = 0; m_run = 0; m_last = -1;
      end
    end
  endtask

  // Leaves the bench at the negedge just after the first post-reset edge.
  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b0;
    repeat (cycles) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    model_reset();
  endtask

  task automatic wait_key_down(input logic level, output int lat);
    lat = 0;
    while (key_down !== level && lat < 100) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    int ev0;
    logic [3:0] exp_col;
    keys = 16'h0;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (col_out !== 4'b1110) $display("FAIL reset_col_out: got %b expected 1110", col_out);
    else n_pass++;
    n_checks++;
    if (keyboard !== 4'h0) $display("FAIL reset_keyboard: got %h expected 0", keyboard);
    else n_pass++;
    n_checks++;
    if (key_down !== 1'b0) $display("FAIL reset_key_down: got %b expected 0", key_down);
    else n_pass++;
    n_checks++;
    if (key_event !== 1'b0) $display("FAIL reset_key_event: got %b expected 0", key_event);
    else n_pass++;
    ev0 = ev_cnt;
    rst = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp_col = ~(4'b0001 << ((k / 4) % 4));
      n_checks++;
      if (col_out !== exp_col)
        $display("FAIL scan_col_out cycle %0d: got %b expected %b", k, col_out, exp_col);
      else n_pass++;
    end
    n_checks++;
    if (ev_cnt !== ev0) $display("FAIL scan_no_event: got %0d events expected 0", ev_cnt - ev0);
    else n_pass++;
    n_checks++;
    if (keyboard !== 4'h0 || key_down !== 1'b0)
      $display("FAIL scan_idle_outputs: got kb=%h kd=%b expected kb=0 kd=0", keyboard, key_down);
    else n_pass++;
  endtask

  task automatic test_bounce();
    int ev0;
    ev0 = ev_cnt;
    @(negedge clk);
    keys = 16'h1 << 15;
    repeat (20) @(negedge clk);
    keys = 16'h0;
    repeat (100) @(negedge clk);
    n_checks++;
    if (ev_cnt !== ev0) $display("FAIL bounce_event: got %0d events expected 0", ev_cnt - ev0);
    else n_pass++;
    n_checks++;
    if (keyboard !== 4'h0) $display("FAIL bounce_keyboard: got %h expected 0", keyboard);
    else n_pass++;
    n_checks++;
    if (key_down !== 1'b0) $display("FAIL bounce_key_down: got %b expected 0", key_down);
    else n_pass++;
  endtask

  task automatic test_clean_press();
    int ev0, lat;
    repeat ($urandom_range(0, 15)) @(negedge clk);
    ev0 = ev_cnt;
    keys = 16'h1 << 9;
    wait_key_down(1'b1, lat);
    n_checks++;
    if (lat < LAT_MIN || lat > LAT_MAX)
      $display("FAIL press_latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    else n_pass++;
    if (lat < 120) repeat (120 - lat) @(negedge clk);
    n_checks++;
    if (ev_cnt - ev0 !== 1) $display("FAIL press_events: got %0d expected 1", ev_cnt - ev0);
    else n_pass++;
    n_checks++;
    if (keyboard !== 4'h9) $display("FAIL press_keyboard: got %h expected 9", keyboard);
    else n_pass++;
    n_checks++;
    if (key_down !== 1'b1) $display("FAIL press_key_down: got %b expected 1", key_down);
    else n_pass++;
  endtask

  task automatic test_release();
    int ev0, lat;
    ev0 = ev_cnt;
    keys = 16'h0;
    wait_key_down(1'b0, lat);
    n_checks++;
    if (lat < LAT_MIN || lat > LAT_MAX)
      $display("FAIL release_latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if (keyboard !== 4'h9) $display("FAIL release_keyboard: got %h expected 9", keyboard);
    else n_pass++;
    n_checks++;
    if (ev_cnt !== ev0) $display("FAIL release_event: got %0d events expected 0", ev_cnt - ev0);
    else n_pass++;
    n_checks++;
    if (key_down !== 1'b0) $display("FAIL release_key_down: got %b expected 0", key_down);
    else n_pass++;
  endtask

  task automatic test_multi_key();
    int ev0, lat;
    ev0 = ev_cnt;
    keys = (16'h1 << 3) | (16'h1 << 4);
    wait_key_down(1'b1, lat);
    n_checks++;
    if (lat < LAT_MIN || lat > LAT_MAX)
      $display("FAIL multi_latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX);
    else n_pass++;
    repeat (40) @(negedge clk);
    n_checks++;
    if (keyboard !== 4'h4) $display("FAIL multi_keyboard: got %h expected 4", keyboard);
    else n_pass++;
    n_checks++;
    if (ev_cnt - ev0 !== 1) $display("FAIL multi_events: got %0d expected 1", ev_cnt - ev0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_held();
    int ev0, lat;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    ev0 = ev_cnt;
    n_checks++;
    if (keyboard !== 4'h0) $display("FAIL midreset_keyboard: got %h expected 0", keyboard);
    else n_pass++;
    n_checks++;
    if (key_down !== 1'b0) $display("FAIL midreset_key_down: got %b expected 0", key_down);
    else n_pass++;
    n_checks++;
    if (col_out !== 4'b1110) $display("FAIL midreset_col_out: got %b expected 1110", col_out);
    else n_pass++;
    wait_key_down(1'b1, lat);
    n_checks++;
    if (lat < LAT_MIN || lat > LAT_MAX + 1)
      $display("FAIL midreset_relatch_latency: got %0d cycles expected %0d..%0d", lat, LAT_MIN, LAT_MAX + 1);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if (keyboard !== 4'h4) $display("FAIL midreset_relatch_keyboard: got %h expected 4", keyboard);
    else n_pass++;
    n_checks++;
    if (ev_cnt - ev0 !== 1) $display("FAIL midreset_relatch_events: got %0d expected 1", ev_cnt - ev0);
    else n_pass++;
    keys = 16'h0;
  endtask

  // Keys change only at scan boundaries, so each DUT scan sees one pattern.
  task automatic test_random();
    int ev0, exp_ev, sel, hold;
    bit ev;
    logic [15:0] k;
    keys = 16'h0;
    do_reset(2);
    ev0 = ev_cnt;
    exp_ev = 0;
    for (int seg = 0; seg < 30; seg++) begin
      sel = $urandom_range(0, 3);
      k = 16'h0;
      if (sel >= 1) k[$urandom_range(0, 15)] = 1'b1;
      if (sel == 3) k[$urandom_range(0, 15)] = 1'b1;
      hold = $urandom_range(1, 5);
      for (int h = 0; h < hold; h++) begin
        keys = k;
        repeat (PERIOD) @(posedge clk);
        @(negedge clk);
        model_scan(prio(k), ev);
        if (ev) exp_ev++;
        n_checks++;
        if (keyboard !== 4'(m_kb) || key_down !== m_held[0] || key_event !== ev)
          $display("FAIL random seg %0d: got kb=%h kd=%b ke=%b expected kb=%h kd=%b ke=%b",
                   seg, keyboard, key_down, key_event, 4'(m_kb), m_held[0], ev);
        else n_pass++;
      end
    end
    n_checks++;
    if (ev_cnt - ev0 !== exp_ev)
      $display("FAIL random_event_total: got %0d expected %0d", ev_cnt - ev0, exp_ev);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_clean_press();
    test_release();
    test_multi_key();
    test_reset_mid_held();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_keypad_scanner.md
# riscv_keypad_scanner

Drives and decodes a 4x4 matrix keypad and produces the debounced key code consumed by the IO bridge's keyboard read port (address 0xfffffc08). It sits between the board keypad pins and the bridge, scanning columns, synchronizing and debouncing rows, and holding the last accepted key for CPU loads. It also provides level and pulse status for future interrupt or LED use.

## Interface
- SCAN_DIV, default 50000: clock cycles each column is driven; minimum 4.
- DEBOUNCE, default 4: consecutive identical full-scan results needed to accept a press or a release; minimum 2; counter width is $clog2(DEBOUNCE+1).
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  synchronous, active-low reset.
- row_in  input  4  keypad rows, active-low (pull-ups on board), asynchronous.
- col_out  output  4  column drive, active-low, exactly one bit low at any time.
- keyboard  output  4  last accepted key code; goes to the bridge's keyboard input.
- key_down  output  1  high while the accepted key is held.
- key_event  output  1  one-cycle pulse when a new press is accepted.

## Operation
- Row sync: row_in passes through a 2-flop synchronizer (row_s). Reset value is 4'hF.
- Column scan: col index 0..3 advances every SCAN_DIV cycles and wraps from 3 to 0. col_out = ~(4'b0001 << col).
- Row sampling: row_s is sampled on the last cycle of each column dwell, which allows SCAN_DIV-1 cycles of settling.
- Scan accumulation: a full scan covers columns 0..3.
  - The first pressed position in priority order is latched: lowest column first, then lowest row.
  - Key code = {row[1:0], col[1:0]}.
  - At the end of column 3, the scan result (found flag + code) is presented for one cycle (scan_done) and the accumulator clears.
- Debounce FSM, evaluated only on scan_done. cnt saturates at DEBOUNCE.
  - IDLE: no key, stay. Key k: go to PRESS_WAIT, cand=k, cnt=1.
  - PRESS_WAIT: result == cand, cnt++. When cnt reaches DEBOUNCE, go to HELD, set keyboard<=cand, key_down<=1, key_event<=1. Different key: cand=new, cnt=1, stay. No key: go to IDLE.
  - HELD: result == keyboard, stay. Anything else (none or a different key): go to RELEASE_WAIT, cnt=1.
  - RELEASE_WAIT: result == keyboard, go back to HELD (no event). Otherwise cnt++. When cnt reaches DEBOUNCE, go to IDLE with key_down<=0.
- keyboard keeps the last accepted code after release and changes only on acceptance. A different key pressed while one is held is accepted only after the release completes and a full press debounce follows.
- key_event is high for exactly one cycle per accepted press and is never high in any other state transition.

## Timing
- Reset (rst=0 at a clock edge) sets:
  - col=0, col_out=4'b1110, dwell counter=0
  - row_s=4'hF, accumulator cleared, state IDLE, cnt=0, cand=0
  - keyboard=4'h0, key_down=0, key_event=0
- A reset asserted mid-operation takes effect on that same edge regardless of state.
- Scan period = 4*SCAN_DIV cycles. First column switch occurs SCAN_DIV cycles after reset release.
- Outputs are registered. keyboard, key_down and key_event update on the cycle after the scan_done that completes debounce.
- Press latency from a stable row_in: at most (DEBOUNCE+1) scan periods + 3 cycles, and at least (DEBOUNCE-1) scan periods.
- Release latency: same bounds as press latency, measured from key_down falling.
- row_in glitches shorter than 2 cycles may be missed; that is allowed.

## Test plan
All scenarios use SCAN_DIV=4 and DEBOUNCE=3 (scan period 16). The keypad model pulls row r low while col_out[c]==0 and key (r,c) is pressed.
- Reset and scan: hold rst=0 for 3 cycles, then release. Required: col_out=1110 for 4 cycles, then 1101, 1011, 0111, 1110 repeating. keyboard=0, key_down=0, key_event never high.
- Clean press: press (2,1) for 120 cycles. Required: exactly one key_event pulse, keyboard=4'h9, key_down=1, press latency within 32..67 cycles.
- Bounce rejection: press (3,3) for 20 cycles, then release for 100 cycles. Required: no key_event, keyboard stays 0, key_down=0.
- Release: after the clean-press scenario, release. Required: key_down falls within 32..67 cycles, keyboard stays 4'h9, no key_event.
- Multiple keys: press (0,3) and (1,0) together. Required: keyboard=4'h4 with a single key_event.
- Reset mid-HELD: while key_down=1, pulse rst=0 for 1 cycle. Required: the next cycle shows keyboard=0, key_down=0, col_out=1110. With the key still pressed, it is re-accepted with a new key_event after debounce.
